// File: rtl/spi_flash_erase.sv
// spi_flash_erase: WREN then sector/bulk erase to SPI NOR flash (mode 0), with optional WIP polling and timeout.
module spi_flash_erase #(
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 24,
    parameter int CS_GAP   = 4,
    parameter int POLL_EN  = 1,
    parameter int POLL_MAX = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              spi_sclk,
    output logic              spi_cs,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int FW = 8 + ADDR_W;
    localparam int SW = $clog2(2 * FW + 1);
    localparam int MC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW = $clog2(MC + 1);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WREN  = 3'd1;
    localparam logic [2:0] GAP1  = 3'd2;
    localparam logic [2:0] ERASE = 3'd3;
    localparam logic [2:0] GAP2  = 3'd4;
    localparam logic [2:0] POLL  = 3'd5;
    localparam logic [2:0] PGAP  = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     seg_q, seg_d, seg_last;
    logic [FW-1:0]     sh_q, sh_d, erase_word;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_q, mode_d, wip_q, wip_d;
    logic              cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              in_gap, timeout, finish;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign spi_sclk = sclk_q;
    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;

    // Segment k of a frame is one SCLK half-period; 2N segments of clocking plus one trailing CS-hold segment.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seg_d      = seg_q;
        sh_d       = sh_q;
        pcnt_d     = pcnt_q;
        addr_d     = addr_q;
        mode_d     = mode_q;
        wip_d      = wip_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        err_d      = err_q;
        done_d     = 1'b0;
        in_gap     = state_q == GAP1 || state_q == GAP2 || state_q == PGAP;
        seg_last   = state_q == POLL ? SW'(32) : (state_q == ERASE && !mode_q) ? SW'(2 * FW) : SW'(16);
        erase_word = mode_q ? {8'hC7, {ADDR_W{1'b0}}} : {8'hD8, addr_q};
        timeout    = state_q == POLL && wip_q && pcnt_q == PW'(POLL_MAX - 1);
        finish     = state_q == POLL && (!wip_q || timeout);
        case (state_q)
            IDLE: if (start) begin
                state_d = WREN;
                busy_d  = 1'b1;
                err_d   = 1'b0;
                pcnt_d  = '0;
                mode_d  = mode;
                addr_d  = addr;
                cs_d    = 1'b0;
                cnt_d   = '0;
                seg_d   = '0;
                sh_d    = {8'h06, {ADDR_W{1'b0}}};
                mosi_d  = sh_d[FW-1];
            end
            DONE: state_d = IDLE;
            default: begin
                if (in_gap) begin
                    if (cnt_q != CW'(CS_GAP - 1)) cnt_d = cnt_q + CW'(1);
                    else if (state_q == GAP2 && POLL_EN == 0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = state_q == GAP1 ? ERASE : POLL;
                        sh_d    = state_q == GAP1 ? erase_word : {8'h05, {ADDR_W{1'b0}}};
                        cs_d    = 1'b0;
                        cnt_d   = '0;
                        seg_d   = '0;
                        mosi_d  = sh_d[FW-1];
                    end
                end else if (cnt_q != CW'(CLK_DIV - 1)) cnt_d = cnt_q + CW'(1);
                else if (seg_q != seg_last) begin
                    cnt_d  = '0;
                    seg_d  = seg_q + SW'(1);
                    sclk_d = !seg_q[0];
                    wip_d  = seg_q[0] ? wip_q : spi_miso;
                    sh_d   = seg_q[0] ? sh_q << 1 : sh_q;
                    mosi_d = seg_q[0] ? sh_q[FW-2] : mosi_q;
                end else begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    pcnt_d  = state_q == POLL ? pcnt_q + PW'(1) : pcnt_q;
                    state_d = state_q == WREN ? GAP1 : state_q == ERASE ? GAP2 : finish ? DONE : PGAP;
                    busy_d  = !finish;
                    done_d  = finish;
                    err_d   = finish ? timeout : err_q;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seg_q   <= '0;
            sh_q    <= '0;
            pcnt_q  <= '0;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            wip_q   <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            sh_q    <= sh_d;
            pcnt_q  <= pcnt_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            wip_q   <= wip_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_erase.sv
// tb_spi_flash_erase: scoreboard bench for two spi_flash_erase configurations with a small M25P16 status model.
module tb_spi_flash_erase;
    typedef struct packed {
        logic [63:0] data;
        int          nrise;
        int          low;
        int          gap;
    } frame_t;

    logic        clk, rst, start_a, start_b, mode, miso;
    logic [23:0] addr;
    logic        busy_a, done_a, err_a, sclk_a, cs_a, mosi_a;
    logic        busy_b, done_b, err_b, sclk_b, cs_b, mosi_b;
    logic        m_cs, m_sclk, m_mosi, m_busy, m_done;
    logic [7:0]  m_cmd;
    bit          sel, force1, prev_cs, prev_sclk;
    int          n_tests, n_fail, wip_init, wip_left, m_rise, hi_run;
    int          busy_cnt, done_cnt, done_tail, bad_idle;
    logic        done_busy;
    frame_t      cur;
    frame_t      obs_q[$];
    frame_t      exp_q[$];

    spi_flash_erase #(.CLK_DIV(2), .ADDR_W(24), .CS_GAP(4), .POLL_EN(0), .POLL_MAX(3)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .start(start_a), .mode(mode), .addr(addr),
        .busy(busy_a), .done(done_a), .err(err_a),
        .spi_sclk(sclk_a), .spi_cs(cs_a), .spi_mosi(mosi_a), .spi_miso(miso)
    );

    spi_flash_erase #(.CLK_DIV(3), .ADDR_W(24), .CS_GAP(2), .POLL_EN(1), .POLL_MAX(3)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .start(start_b), .mode(mode), .addr(addr),
        .busy(busy_b), .done(done_b), .err(err_b),
        .spi_sclk(sclk_b), .spi_cs(cs_b), .spi_mosi(mosi_b), .spi_miso(miso)
    );

    assign m_cs   = sel ? cs_b : cs_a;
    assign m_sclk = sel ? sclk_b : sclk_a;
    assign m_mosi = sel ? mosi_b : mosi_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    // Flash shifts status out MSB first after the RDSR opcode; only WIP (bit 0, 16th clock) can be 1.
    assign miso = force1 | (m_cmd == 8'h05 && m_rise == 15 && wip_left > 0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic frame_t fr(input logic [63:0] d, input int n, input int cd, input int g);
        fr.data  = d;
        fr.nrise = n;
        fr.low   = (2 * n + 1) * cd;
        fr.gap   = g;
    endfunction

    initial begin
        prev_cs = 1'b1;
        forever begin
            @(negedge clk);
            if (m_cs && (m_mosi || m_sclk)) bad_idle++;
            if (m_cs) hi_run = (!m_busy && !m_done) ? 0 : hi_run + 1;
            if (!m_cs && prev_cs) begin
                cur = '0;
                cur.gap = hi_run;
                hi_run = 0;
                m_rise = 0;
                m_cmd = 8'h00;
            end
            if (!m_cs) begin
                cur.low++;
                if (m_sclk && !prev_sclk) begin
                    cur.data = {cur.data[62:0], m_mosi};
                    cur.nrise++;
                    m_rise = cur.nrise;
                    if (cur.nrise == 8) m_cmd = cur.data[7:0];
                end
            end
            if (m_cs && !prev_cs) begin
                obs_q.push_back(cur);
                if (m_cmd == 8'hD8 || m_cmd == 8'hC7) wip_left = wip_init;
                else if (m_cmd == 8'h05 && wip_left > 0) wip_left--;
                m_cmd = 8'h00;
            end
            if (m_busy) busy_cnt++;
            if (m_done) begin
                done_cnt++;
                done_tail = hi_run;
                done_busy = m_busy;
            end
            prev_cs = m_cs;
            prev_sclk = m_sclk;
        end
    end

    task automatic go(input bit b, input bit md, input logic [23:0] a);
        mode = md;
        addr = a;
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (m_done) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cs_a, sclk_a, mosi_a, busy_a, done_a, err_a} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_a_held: got %b, expected 100000", {cs_a, sclk_a, mosi_a, busy_a, done_a, err_a});
        end
        n_tests++;
        if ({cs_b, sclk_b, mosi_b, busy_b, done_b, err_b} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_b_held: got %b, expected 100000", {cs_b, sclk_b, mosi_b, busy_b, done_b, err_b});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cs_a, sclk_a, mosi_a, busy_a, done_a, err_a} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_a_idle: got %b, expected 100000", {cs_a, sclk_a, mosi_a, busy_a, done_a, err_a});
        end
        n_tests++;
        if ({cs_b, sclk_b, mosi_b, busy_b, done_b, err_b} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_b_idle: got %b, expected 100000", {cs_b, sclk_b, mosi_b, busy_b, done_b, err_b});
        end
        obs_q.delete();
    endtask

    task automatic test_bulk;
        bit ok;
        frame_t e, o;
        sel = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        exp_q.push_back(fr(64'h06, 8, 2, 0));
        exp_q.push_back(fr(64'hC7, 8, 2, 4));
        go(1'b0, 1'b1, 24'h555555);
        wait_done(500, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL bulk_done: got no done, expected done within 500 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bulk_frame: got data=%h bits=%0d low=%0d gap=%0d, expected data=%h bits=%0d low=%0d gap=%0d",
                         o.data, o.nrise, o.low, o.gap, e.data, e.nrise, e.low, e.gap);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL bulk_extra_frames: got %0d, expected 0", obs_q.size()); end
        n_tests++;
        if (busy_cnt != 76) begin n_fail++; $display("FAIL bulk_busy_cycles: got %0d, expected 76", busy_cnt); end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL bulk_done_pulses: got %0d, expected 1", done_cnt); end
        n_tests++;
        if (done_busy !== 1'b0) begin n_fail++; $display("FAIL bulk_busy_at_done: got %b, expected 0", done_busy); end
        n_tests++;
        if (done_tail != 5) begin n_fail++; $display("FAIL bulk_done_tail: got %0d, expected 5", done_tail); end
        n_tests++;
        if (bad_idle != 0) begin n_fail++; $display("FAIL bulk_idle_lines: got %0d, expected 0", bad_idle); end
        obs_q.delete();
    endtask

    task automatic test_sector;
        bit ok;
        frame_t e, o;
        sel = 1'b0;
        busy_cnt = 0;
        exp_q.push_back(fr(64'h06, 8, 2, 0));
        exp_q.push_back(fr(64'hD81A2B3C, 32, 2, 4));
        go(1'b0, 1'b0, 24'h1A2B3C);
        wait_done(800, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL sector_done: got no done, expected done within 800 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sector_frame: got data=%h bits=%0d low=%0d gap=%0d, expected data=%h bits=%0d low=%0d gap=%0d",
                         o.data, o.nrise, o.low, o.gap, e.data, e.nrise, e.low, e.gap);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL sector_extra_frames: got %0d, expected 0", obs_q.size()); end
        n_tests++;
        if (busy_cnt != 172) begin n_fail++; $display("FAIL sector_busy_cycles: got %0d, expected 172", busy_cnt); end
        n_tests++;
        if (err_a !== 1'b0) begin n_fail++; $display("FAIL sector_err: got %b, expected 0", err_a); end
        obs_q.delete();
    endtask

    task automatic test_poll;
        bit ok;
        frame_t e, o;
        sel = 1'b1;
        done_cnt = 0;
        wip_init = 2;
        exp_q.push_back(fr(64'h06, 8, 3, 0));
        exp_q.push_back(fr(64'hD80ABCDE, 32, 3, 2));
        repeat (3) exp_q.push_back(fr(64'h0500, 16, 3, 2));
        go(1'b1, 1'b0, 24'h0ABCDE);
        wait_done(3000, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL poll_done: got no done, expected done within 3000 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL poll_frame: got data=%h bits=%0d low=%0d gap=%0d, expected data=%h bits=%0d low=%0d gap=%0d",
                         o.data, o.nrise, o.low, o.gap, e.data, e.nrise, e.low, e.gap);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL poll_extra_frames: got %0d, expected 0", obs_q.size()); end
        n_tests++;
        if (done_tail != 1) begin n_fail++; $display("FAIL poll_done_tail: got %0d, expected 1", done_tail); end
        n_tests++;
        if (err_b !== 1'b0) begin n_fail++; $display("FAIL poll_err: got %b, expected 0", err_b); end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL poll_done_pulses: got %0d, expected 1", done_cnt); end
        obs_q.delete();
    endtask

    task automatic test_timeout;
        bit ok;
        frame_t e, o;
        sel = 1'b1;
        force1 = 1'b1;
        exp_q.push_back(fr(64'h06, 8, 3, 0));
        exp_q.push_back(fr(64'hC7, 8, 3, 2));
        repeat (3) exp_q.push_back(fr(64'h0500, 16, 3, 2));
        go(1'b1, 1'b1, 24'h0);
        wait_done(3000, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL timeout_done: got no done, expected done within 3000 cycles"); end
        n_tests++;
        if (err_b !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b, expected 1", err_b); end
        force1 = 1'b0;
        wip_init = 0;
        exp_q.push_back(fr(64'h06, 8, 3, 0));
        exp_q.push_back(fr(64'hD8000100, 32, 3, 2));
        exp_q.push_back(fr(64'h0500, 16, 3, 2));
        go(1'b1, 1'b0, 24'h000100);
        n_tests++;
        if ({busy_b, err_b} !== 2'b10) begin n_fail++; $display("FAIL timeout_err_clear: got busy,err=%b, expected 10", {busy_b, err_b}); end
        wait_done(3000, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok || err_b !== 1'b0) begin n_fail++; $display("FAIL timeout_rerun: got done=%b err=%b, expected done=1 err=0", ok, err_b); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_frame: got data=%h bits=%0d low=%0d gap=%0d, expected data=%h bits=%0d low=%0d gap=%0d",
                         o.data, o.nrise, o.low, o.gap, e.data, e.nrise, e.low, e.gap);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL timeout_extra_frames: got %0d, expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_ignore_start;
        bit ok;
        frame_t e, o;
        sel = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        exp_q.push_back(fr(64'h06, 8, 2, 0));
        exp_q.push_back(fr(64'hC7, 8, 2, 4));
        go(1'b0, 1'b1, 24'h0);
        repeat (10) @(negedge clk);
        mode = 1'b0;
        addr = 24'hFFFFFF;
        start_a = 1'b1;
        repeat (3) @(negedge clk);
        start_a = 1'b0;
        wait_done(500, ok);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ignore_done: got no done, expected done within 500 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ignore_frame: got data=%h bits=%0d low=%0d gap=%0d, expected data=%h bits=%0d low=%0d gap=%0d",
                         o.data, o.nrise, o.low, o.gap, e.data, e.nrise, e.low, e.gap);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL ignore_extra_frames: got %0d, expected 0", obs_q.size()); end
        n_tests++;
        if (busy_cnt != 76 || busy_a !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got cycles=%0d busy=%b, expected 76 and 0", busy_cnt, busy_a); end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d, expected 1", done_cnt); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        bit ok;
        frame_t e, o;
        sel = 1'b0;
        go(1'b0, 1'b0, 24'h123456);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({cs_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b, expected 10000", {cs_a, sclk_a, mosi_a, busy_a, done_a});
        end
        rst = 1'b0;
        done_cnt = 0;
        repeat (200) @(negedge clk);
        n_tests++;
        if (done_cnt != 0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got done=%0d busy=%b, expected 0 and 0", done_cnt, busy_a); end
        obs_q.delete();
        busy_cnt = 0;
        exp_q.push_back(fr(64'h06, 8, 2, 0));
        exp_q.push_back(fr(64'hD8123456, 32, 2, 4));
        go(1'b0, 1'b0, 24'h123456);
        wait_done(800, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL midreset_rerun_done: got done=%0d, expected 1", done_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_frame: got data=%h bits=%0d low=%0d gap=%0d, expected data=%h bits=%0d low=%0d gap=%0d",
                         o.data, o.nrise, o.low, o.gap, e.data, e.nrise, e.low, e.gap);
            end
        end
        n_tests++;
        if (busy_cnt != 172) begin n_fail++; $display("FAIL midreset_busy_cycles: got %0d, expected 172", busy_cnt); end
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode = 1'b0;
        addr = '0;
        sel = 1'b0;
        force1 = 1'b0;
        test_reset;
        test_bulk;
        test_sector;
        test_poll;
        test_timeout;
        test_ignore_start;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
